// File: rtl/crc16_frame_appender.sv
// rtl/crc16_frame_appender.sv - byte-stream pass-through that appends a per-frame CRC-16/X-25
// Each frame reloads INIT; bypass frames pass through with no CRC tail.
module crc16_frame_appender #(
  parameter logic [15:0] INIT       = 16'hFFFF,
  parameter logic [15:0] OUTPUT_XOR = 16'hFFFF,
  parameter int          CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_last,
  input  logic                 cfg_bypass,
  output logic [7:0]           m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, DATA, CRC_LO, CRC_HI} state_t;

  state_t      state, state_nx;
  logic [15:0] crc, crc_nx, crc_final;
  logic        bypass_q, bypass_nx;
  logic        free, in_xfer, load, ld_last, cnt_inc;
  logic [7:0]  ld_data;

  function automatic logic [7:0] rev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  function automatic logic [15:0] rev16(input logic [15:0] d);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = d[15-i];
    return r;
  endfunction

  // Reflected-input CRC realised as an MSB-first Galois update on the reversed byte.
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {rev8(d), 8'h00};
    for (int i = 0; i < 8; i++) r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    return r;
  endfunction

  assign crc_final = rev16(crc) ^ OUTPUT_XOR;
  assign free      = !m_valid || m_ready;
  assign s_ready   = !rst && free && (state == IDLE || state == DATA);
  assign in_xfer   = s_valid && s_ready;
  assign busy      = (state != IDLE) || (in_xfer && !(s_last && cfg_bypass));

  always_comb begin
    state_nx  = state;
    crc_nx    = crc;
    bypass_nx = bypass_q;
    load      = 1'b0;
    ld_data   = m_data;
    ld_last   = m_last;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: if (in_xfer) begin
        bypass_nx = cfg_bypass;
        crc_nx    = crc_step(INIT, s_data);
        load      = 1'b1;
        ld_data   = s_data;
        ld_last   = s_last && cfg_bypass;
        if (!s_last) begin
          state_nx = DATA;
        end else if (cfg_bypass) begin
          state_nx = IDLE;
          cnt_inc  = 1'b1;
          crc_nx   = INIT;
        end else begin
          state_nx = CRC_LO;
        end
      end
      DATA: if (in_xfer) begin
        crc_nx  = crc_step(crc, s_data);
        load    = 1'b1;
        ld_data = s_data;
        ld_last = s_last && bypass_q;
        if (s_last) begin
          if (bypass_q) begin
            state_nx = IDLE;
            cnt_inc  = 1'b1;
            crc_nx   = INIT;
          end else begin
            state_nx = CRC_LO;
          end
        end
      end
      CRC_LO: if (free) begin
        load     = 1'b1;
        ld_data  = crc_final[7:0];
        ld_last  = 1'b0;
        state_nx = CRC_HI;
      end
      CRC_HI: if (free) begin
        load     = 1'b1;
        ld_data  = crc_final[15:8];
        ld_last  = 1'b1;
        cnt_inc  = 1'b1;
        crc_nx   = INIT;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      crc       <= INIT;
      bypass_q  <= 1'b0;
      frame_cnt <= '0;
      m_valid   <= 1'b0;
      m_data    <= 8'h00;
      m_last    <= 1'b0;
    end else begin
      state    <= state_nx;
      crc      <= crc_nx;
      bypass_q <= bypass_nx;
      if (cnt_inc) frame_cnt <= frame_cnt + CNT_WIDTH'(1);
      // Output fields only change on a load; otherwise a stalled byte holds.
      if (load) begin
        m_valid <= 1'b1;
        m_data  <= ld_data;
        m_last  <= ld_last;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_crc16_frame_appender.sv
// tb/tb_crc16_frame_appender.sv - directed self-checking bench for crc16_frame_appender
// A negedge monitor collects output transfers and checks the stall hold rule.
module tb_crc16_frame_appender;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        cfg_bypass = 1'b0;
  logic        m_ready = 1'b1;
  logic        s_ready, m_valid, m_last, busy;
  logic [7:0]  m_data;
  logic [15:0] frame_cnt;
  logic        s2_ready, m2_valid, m2_last, busy2;
  logic [7:0]  m2_data;
  logic [1:0]  frame_cnt2;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit bp_en = 1'b0;
  logic [8:0] out_q [$];
  int         out_cyc [$];

  crc16_frame_appender dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .s_last(s_last), .cfg_bypass(cfg_bypass), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .busy(busy), .frame_cnt(frame_cnt)
  );

  crc16_frame_appender #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s2_ready),
    .s_last(s_last), .cfg_bypass(cfg_bypass), .m_data(m2_data), .m_valid(m2_valid),
    .m_ready(m_ready), .m_last(m2_last), .busy(busy2), .frame_cnt(frame_cnt2)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          total++;
          if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
            bad++;
            $display("FAIL hold: got v=%0b d=%02h l=%0b want v=1 d=%02h l=%0b",
                     m_valid, m_data, m_last, prev_data, prev_last);
          end
        end
        if (m_valid && !m_ready) begin
          total++;
          if (s_ready !== 1'b0) begin
            bad++;
            $display("FAIL s_ready_stall: got %0b want 0", s_ready);
          end
        end
        if (m_valid && m_ready) begin
          out_q.push_back({m_last, m_data});
          out_cyc.push_back(cyc);
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    cfg_bypass = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_q.delete();
    out_cyc.delete();
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, input logic b);
    int n = 0;
    s_data = d;
    s_last = l;
    cfg_bypass = b;
    s_valid = 1'b1;
    @(negedge clk);
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      total++;
      bad++;
      $display("FAIL send_timeout: byte %02h not accepted in %0d cycles", d, n);
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic send_check_frame();
    for (int i = 0; i < 9; i++) send_byte(8'h31 + 8'(i), i == 8, 1'b0);
  endtask

  task automatic wait_out(input int n);
    int k = 0;
    while (out_q.size() < n && k < 400) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    total++;
    if (out_q.size() != n) begin
      bad++;
      $display("FAIL out_count: got %0d want %0d", out_q.size(), n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (m_valid !== 1'b0 || m_data !== 8'h00 || m_last !== 1'b0 || s_ready !== 1'b0 ||
        busy !== 1'b0 || frame_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset: got v=%0b d=%02h l=%0b rdy=%0b busy=%0b cnt=%0d want all 0",
               m_valid, m_data, m_last, s_ready, busy, frame_cnt);
    end
    do_reset();
  endtask

  task automatic test_check_string();
    logic [8:0] exp [$];
    do_reset();
    for (int i = 0; i < 9; i++) exp.push_back({1'b0, 8'h31 + 8'(i)});
    exp.push_back({1'b0, 8'h6E});
    exp.push_back({1'b1, 8'h90});
    send_byte(8'h31, 1'b0, 1'b0);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_mid: got %0b want 1", busy);
    end
    for (int i = 1; i < 9; i++) send_byte(8'h31 + 8'(i), i == 8, 1'b0);
    wait_out(11);
    for (int i = 0; i < 11 && i < out_q.size(); i++) begin
      total++;
      if (out_q[i] !== exp[i]) begin
        bad++;
        $display("FAIL t1_byte%0d: got %03h want %03h", i, out_q[i], exp[i]);
      end
    end
    total++;
    if (out_cyc.size() != 11 || out_cyc[10] - out_cyc[0] != 10) begin
      bad++;
      $display("FAIL t1_consecutive: got span %0d want 10",
               out_cyc.size() == 11 ? out_cyc[10] - out_cyc[0] : -1);
    end
    total++;
    if (frame_cnt !== 16'd1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL t1_cnt_busy: got cnt=%0d busy=%0b want 1/0", frame_cnt, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp [$];
    do_reset();
    exp.push_back({1'b0, 8'h00});
    exp.push_back({1'b0, 8'h78});
    exp.push_back({1'b1, 8'hF0});
    for (int i = 0; i < 9; i++) exp.push_back({1'b0, 8'h31 + 8'(i)});
    exp.push_back({1'b0, 8'h6E});
    exp.push_back({1'b1, 8'h90});
    send_byte(8'h00, 1'b1, 1'b0);
    send_check_frame();
    wait_out(14);
    for (int i = 0; i < 14 && i < out_q.size(); i++) begin
      total++;
      if (out_q[i] !== exp[i]) begin
        bad++;
        $display("FAIL t2_byte%0d: got %03h want %03h", i, out_q[i], exp[i]);
      end
    end
    total++;
    if (frame_cnt !== 16'd2) begin
      bad++;
      $display("FAIL t2_cnt: got %0d want 2", frame_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] exp [$];
    do_reset();
    for (int i = 0; i < 9; i++) exp.push_back({1'b0, 8'h31 + 8'(i)});
    exp.push_back({1'b0, 8'h6E});
    exp.push_back({1'b1, 8'h90});
    bp_en = 1'b1;
    send_check_frame();
    wait_out(11);
    bp_en = 1'b0;
    for (int i = 0; i < 11 && i < out_q.size(); i++) begin
      total++;
      if (out_q[i] !== exp[i]) begin
        bad++;
        $display("FAIL t3_byte%0d: got %03h want %03h", i, out_q[i], exp[i]);
      end
    end
    total++;
    if (frame_cnt !== 16'd1) begin
      bad++;
      $display("FAIL t3_cnt: got %0d want 1", frame_cnt);
    end
  endtask

  task automatic test_bypass();
    logic [8:0] exp [$];
    do_reset();
    exp.push_back({1'b0, 8'hAA});
    exp.push_back({1'b0, 8'hBB});
    exp.push_back({1'b0, 8'hCC});
    exp.push_back({1'b1, 8'hDD});
    send_byte(8'hAA, 1'b0, 1'b1);
    send_byte(8'hBB, 1'b0, 1'b0);
    send_byte(8'hCC, 1'b0, 1'b1);
    send_byte(8'hDD, 1'b1, 1'b0);
    wait_out(4);
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      total++;
      if (out_q[i] !== exp[i]) begin
        bad++;
        $display("FAIL t4_byte%0d: got %03h want %03h", i, out_q[i], exp[i]);
      end
    end
    total++;
    if (frame_cnt !== 16'd1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL t4_cnt_busy: got cnt=%0d busy=%0b want 1/0", frame_cnt, busy);
    end
  endtask

  task automatic test_mid_reset();
    logic [8:0] exp [$];
    bit any_last = 1'b0;
    out_q.delete();
    out_cyc.delete();
    send_check_frame();
    rst = 1'b1;
    #1;
    total++;
    if (m_valid !== 1'b0 || frame_cnt !== 16'd0) begin
      bad++;
      $display("FAIL t5_async: got v=%0b cnt=%0d want 0/0", m_valid, frame_cnt);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    foreach (out_q[i]) if (out_q[i][8]) any_last = 1'b1;
    total++;
    if (out_q.size() != 8 || any_last) begin
      bad++;
      $display("FAIL t5_dropped: got n=%0d last=%0b want n=8 last=0", out_q.size(), any_last);
    end
    @(posedge clk);
    #1;
    out_q.delete();
    out_cyc.delete();
    exp.push_back({1'b0, 8'h6E});
    exp.push_back({1'b1, 8'h90});
    send_check_frame();
    wait_out(11);
    for (int i = 0; i < 2 && out_q.size() == 11; i++) begin
      total++;
      if (out_q[9 + i] !== exp[i]) begin
        bad++;
        $display("FAIL t5_tail%0d: got %03h want %03h", i, out_q[9 + i], exp[i]);
      end
    end
    total++;
    if (frame_cnt !== 16'd1) begin
      bad++;
      $display("FAIL t5_cnt: got %0d want 1", frame_cnt);
    end
  endtask

  task automatic test_cnt_wrap();
    logic [1:0] exp [$];
    do_reset();
    exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 5; i++) begin
      send_byte(8'h10 + 8'(i), 1'b1, 1'b1);
      total++;
      if (frame_cnt2 !== exp[i]) begin
        bad++;
        $display("FAIL t6_wrap%0d: got %0d want %0d", i, frame_cnt2, exp[i]);
      end
    end
    wait_out(5);
    total++;
    if (frame_cnt !== 16'd5) begin
      bad++;
      $display("FAIL t6_wide_cnt: got %0d want 5", frame_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_check_string();
    test_back_to_back();
    test_backpressure();
    test_bypass();
    test_mid_reset();
    test_cnt_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
